// File: rtl/mtx_pkg.sv
`default_nettype none
// ============================================================================
// mtx_pkg : shared sizes and sequencer state encoding for the MOPA sequencer
// Rev 1.0 : initial release
// ============================================================================
package mtx_pkg;

   localparam int N_ROWS  = 4;
   localparam int ELEM_W  = 32;
   localparam int ROW_W   = N_ROWS * ELEM_W;
   localparam int RIDX_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
   localparam int MREG_AW = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_MAC   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_WRITE = 3'd4,
      ST_DRAIN = 3'd5
   } mopa_state_e;

endpackage
`default_nettype wire

// File: rtl/mopa_seq.sv
`default_nettype none
// ============================================================================
// mopa_seq : row-by-row sequencer for a matrix outer-product accumulate (MOPA)
// Rev 1.0 : initial release
// ============================================================================
module mopa_seq
   import mtx_pkg::*;
#(
   parameter int  N_ROWS  = mtx_pkg::N_ROWS,
   parameter int  ELEM_W  = mtx_pkg::ELEM_W,
   parameter int  MREG_AW = mtx_pkg::MREG_AW,
   localparam int ROW_W   = N_ROWS * ELEM_W,
   localparam int RIDX_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               issue_valid,
   input  logic [MREG_AW-1:0] issue_rd,
   input  logic [ROW_W-1:0]   issue_a,
   input  logic [ROW_W-1:0]   issue_b,
   output logic               issue_ready,
   output logic               busy,
   output logic               mrd_en,
   output logic [MREG_AW-1:0] mrd_mat,
   output logic [RIDX_W-1:0]  mrd_row,
   input  logic [ROW_W-1:0]   mrd_data,
   output logic               mac_valid,
   input  logic               mac_ready,
   output logic [ROW_W-1:0]   mac_acc,
   output logic [ELEM_W-1:0]  mac_scalar,
   output logic [ROW_W-1:0]   mac_vec,
   input  logic               mac_res_valid,
   input  logic [ROW_W-1:0]   mac_res,
   output logic               mwr_en,
   output logic [MREG_AW-1:0] mwr_mat,
   output logic [RIDX_W-1:0]  mwr_row,
   output logic [ROW_W-1:0]   mwr_data,
   output logic               done
);

   localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(N_ROWS - 1);

   mopa_state_e        state;
   logic [RIDX_W-1:0]  row;
   logic [MREG_AW-1:0] rd_q;
   logic [ROW_W-1:0]   a_q;
   logic [ROW_W-1:0]   b_q;
   logic [ROW_W-1:0]   acc_q;
   logic [ROW_W-1:0]   res_q;
   logic               mac_first;
   logic [ELEM_W-1:0]  a_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         row       <= '0;
         rd_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         res_q     <= '0;
         mac_first <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (issue_valid && !flush) begin
                  rd_q  <= issue_rd;
                  a_q   <= issue_a;
                  b_q   <= issue_b;
                  row   <= '0;
                  state <= ST_READ;
               end
            end
            ST_READ: begin
               mac_first <= !flush;
               state     <= flush ? ST_IDLE : ST_MAC;
            end
            ST_MAC: begin
               // Read data is only guaranteed during the first MAC cycle; hold it for stalls.
               if (mac_first)
                  acc_q <= mrd_data;
               mac_first <= 1'b0;
               if (mac_ready)
                  state <= flush ? ST_DRAIN : ST_WAIT;
               else if (flush)
                  state <= ST_IDLE;
            end
            ST_WAIT: begin
               if (mac_res_valid) begin
                  if (flush) begin
                     state <= ST_IDLE;
                  end else begin
                     res_q <= mac_res;
                     state <= ST_WRITE;
                  end
               end else if (flush) begin
                  state <= ST_DRAIN;
               end
            end
            ST_WRITE: begin
               if (flush || row == LAST_ROW) begin
                  state <= ST_IDLE;
               end else begin
                  row   <= row + 1'b1;
                  state <= ST_READ;
               end
            end
            ST_DRAIN: begin
               // The in-flight MAC result must be swallowed before a new operation starts.
               if (mac_res_valid)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      a_sel = '0;
      for (int k = 0; k < N_ROWS; k++) begin
         if (row == RIDX_W'(k))
            a_sel = a_q[k*ELEM_W +: ELEM_W];
      end
   end

   assign issue_ready = (state == ST_IDLE);
   assign busy        = (state != ST_IDLE);

   assign mrd_en      = (state == ST_READ);
   assign mrd_mat     = rd_q;
   assign mrd_row     = row;

   assign mac_valid   = (state == ST_MAC);
   assign mac_acc     = mac_first ? mrd_data : acc_q;
   assign mac_scalar  = a_sel;
   assign mac_vec     = b_q;

   assign mwr_en      = (state == ST_WRITE) && !flush;
   assign mwr_mat     = rd_q;
   assign mwr_row     = row;
   assign mwr_data    = res_q;
   assign done        = mwr_en && (row == LAST_ROW);

endmodule
`default_nettype wire

// File: doc/mopa_seq.md
MOPA_SEQ -- requirements
Module: mopa_seq

Interface
REQ-001 Parameter N_ROWS, default 4, rows and elements per matrix slice; power of two.
REQ-002 Parameter ELEM_W, default 32, element width; ROW_W = N_ROWS*ELEM_W, RIDX_W = log2(N_ROWS).
REQ-003 Parameter MREG_AW, default 2, matrix-register index width.
REQ-004 Ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  flush  in  1  pipeline flush; aborts the current operation.
  issue_valid  in  1  Mtype MOPA presented from EX.
  issue_rd  in  MREG_AW  destination/accumulator matrix register.
  issue_a  in  ROW_W  column vector a; element k at bits [k*ELEM_W +: ELEM_W].
  issue_b  in  ROW_W  row vector b; same packing as issue_a.
  issue_ready  out  1  sequencer can accept an issue.
  busy  out  1  pipeline stall request.
  mrd_en  out  1  matrix row read strobe.
  mrd_mat  out  MREG_AW  matrix register to read.
  mrd_row  out  RIDX_W  row to read.
  mrd_data  in  ROW_W  read data, valid exactly 1 cycle after mrd_en.
  mac_valid  out  1  row-MAC request.
  mac_ready  in  1  row-MAC accepts the request.
  mac_acc  out  ROW_W  accumulator row.
  mac_scalar  out  ELEM_W  a[row].
  mac_vec  out  ROW_W  vector b.
  mac_res_valid  in  1  row-MAC result valid.
  mac_res  in  ROW_W  acc + a[row]*b, elementwise.
  mwr_en  out  1  matrix row write strobe.
  mwr_mat  out  MREG_AW  matrix register to write.
  mwr_row  out  RIDX_W  row to write.
  mwr_data  out  ROW_W  row write data.
  done  out  1  one-cycle completion pulse.

Function
REQ-005 States: IDLE, READ, MAC, WAIT, WRITE, DRAIN.
REQ-006 issue_ready = 1 only in IDLE; busy = 1 in every state except IDLE.
REQ-007 Accept when IDLE && issue_valid && !flush: latch issue_rd, issue_a and issue_b; row := 0; next state READ.
REQ-008 READ: mrd_en=1, mrd_mat=latched rd, mrd_row=row; always proceed to MAC.
REQ-009 MAC: capture mrd_data into the acc register on state entry; hold mac_valid=1 with stable mac_acc, mac_scalar=a[row] and mac_vec=b until mac_valid && mac_ready, then go to WAIT.
REQ-010 WAIT: on mac_res_valid, register mac_res and go to WRITE; mac_res_valid is never accepted in the handshake cycle itself.
REQ-011 WRITE: mwr_en=1, mwr_mat=rd, mwr_row=row, mwr_data=registered result. If row==N_ROWS-1, assert done in the same cycle and go to IDLE; otherwise row++ and go to READ.
REQ-012 Minimum per-row cost is 4 cycles (mac_ready=1, mac_res_valid one cycle after the handshake). Minimum total from accept to done is 4*N_ROWS cycles.
REQ-013 Row counter is RIDX_W bits and must not wrap within an operation; rows are processed in order 0..N_ROWS-1.
REQ-014 Flush in READ, MAC (with no handshake that cycle) or WRITE: next state IDLE; mwr_en and done are forced to 0 in the flush cycle.
REQ-015 Flush in WAIT, or in MAC coinciding with the handshake: next state DRAIN. DRAIN discards one mac_res_valid, then goes to IDLE; busy stays 1 throughout DRAIN.
REQ-016 If flush and mac_res_valid occur together in WAIT, the result is discarded and the next state is IDLE.
REQ-017 In IDLE, mac_res_valid is ignored. Simultaneous issue_valid and flush: flush wins and there is no accept.
REQ-018 All strobe outputs (mrd_en, mac_valid, mwr_en, done) are 0 outside their stated states.

Reset
REQ-019 While rst=1: state=IDLE, row=0, latched operands and result registers=0; all outputs 0 except issue_ready=1.
REQ-020 Reset mid-operation abandons the operation immediately; no write or done is produced afterwards.

Structure
REQ-021 Shared package mtx_pkg holds N_ROWS, ELEM_W, ROW_W, RIDX_W, MREG_AW and the state enumeration.
REQ-022 Single module; no sub-module is required. The row-MAC and the matrix register file are external.

Verification
REQ-023 N_ROWS=4, mac_ready=1, result 1 cycle after the handshake; a={1,2,3,4}, b={1,1,1,1}, acc all 0 -> rows written as {1,1,1,1}, {2,2,2,2}, {3,3,3,3}, {4,4,4,4}; done in cycle 16 after accept.
REQ-024 mac_ready held low 3 cycles on row 2 -> mac_valid and its operands stay stable; done slips by exactly 3 cycles.
REQ-025 Flush in WAIT of row 1, result arriving 2 cycles later -> DRAIN consumes it; no mwr_en; issue_ready returns the cycle after the result.
REQ-026 issue_valid and flush both high in IDLE -> no accept; busy stays 0.
REQ-027 rst asserted during WRITE of row 2 -> outputs reach reset values asynchronously; no further mwr_en or done.
REQ-028 Back-to-back issues to rd=1 then rd=2 -> second accepted the cycle after the first done; rows of each written to the correct mwr_mat.
